pixel_array_readout_ctrl: RTL and testbench
===========================================

// Module: pixel_array_readout_ctrl
// PURPOSE
//  Parametrised successor of the two-row camera controller. Sequences erase, exposure and
//  row-by-row readout for a NUM_ROWS pixel array, with exposure time adjustable at runtime.
//  Adds single-shot and continuous capture, abort, and busy/row/frame-done status outputs.
//  Drives the pixel electronics (NRE bus, ADC, Expose, Erase) directly.
// PARAMETERS
//  NUM_ROWS      2   rows read out per frame; must be >=1
//  EXP_W         5   width of the exposure-time register
//  EXP_MIN       2   minimum exposure in cycles; must be >=1
//  EXP_MAX       30  maximum exposure in cycles; must be <= 2**EXP_W-1
//  EXP_DEFAULT   4   exposure loaded at reset; must satisfy EXP_MIN <= EXP_DEFAULT <= EXP_MAX
//  EXP_STEP      1   increment/decrement per adjust pulse
//  ERASE_CYCLES  2   length of the Erase pulse
//  SETUP_CYCLES  1   NRE-low settle time before ADC per row
//  ADC_CYCLES    2   ADC-high time per row
// PORTS
//  Clk           in   1         single clock, all logic on rising edge
//  Reset         in   1         synchronous, active-high
//  Exp_increase  in   1         level-sampled increase request
//  Exp_decrease  in   1         level-sampled decrease request
//  Init          in   1         start capture
//  Continuous    in   1         1 = auto-restart after each frame
//  Abort         in   1         terminate current frame
//  NRE           out  NUM_ROWS  active-low row read enable, one-hot-low while reading
//  ADC           out  1         ADC conversion enable
//  Expose        out  1         exposure gate
//  Erase         out  1         pixel erase
//  Busy          out  1         high whenever not IDLE
//  Row_idx       out  RW        current row, RW=max(1,$clog2(NUM_ROWS))
//  Exp_time      out  EXP_W     current exposure setting
//  Frame_done    out  1         one-cycle pulse at frame completion
// BEHAVIOUR
//  - All outputs are registered. Reset values: NRE all 1s, ADC=Erase=Expose=Busy=Frame_done=0,
//    Row_idx=0, Exp_time=EXP_DEFAULT, FSM=IDLE. Reset has priority over every input.
//  - FSM: IDLE -> ERASE -> EXPOSE -> SETUP -> CONVERT -> (SETUP of the next row | DONE)
//    -> IDLE, or -> ERASE when Continuous=1 in DONE.
//  - IDLE: Init=1 at edge t gives Erase=1 from cycle t+1 for ERASE_CYCLES cycles. Exp_time is
//    snapshotted into exp_cnt at that edge.
//  - EXPOSE: Expose=1 for exactly the snapshotted Exp_time cycles.
//  - SETUP: NRE[Row_idx]=0 for SETUP_CYCLES cycles.
//  - CONVERT: NRE[Row_idx]=0 and ADC=1 for ADC_CYCLES cycles. Row_idx then increments;
//    after row NUM_ROWS-1 the FSM goes to DONE.
//  - DONE: lasts 1 cycle with Frame_done=1 and NRE all 1s. Row_idx returns to 0 on leaving DONE.
//  - Frame length = ERASE_CYCLES + Exp_time + NUM_ROWS*(SETUP_CYCLES+ADC_CYCLES) + 1 cycles.
//  - Output exclusivity: Erase, Expose and ADC are mutually exclusive. At most one NRE bit is
//    low, and only in SETUP/CONVERT.
//  - Exposure adjust is accepted only in IDLE and when Init=0.
//    - Increase: Exp_time = min(Exp_time+EXP_STEP, EXP_MAX).
//    - Decrease: Exp_time = max(Exp_time-EXP_STEP, EXP_MIN).
//    - Both high at once: no change.
//    - Arithmetic uses EXP_W+1 bits, so there is no wrap-around.
//    - Each cycle held high applies one step.
//  - Init in IDLE wins over adjust requests in the same cycle. Init while Busy is ignored.
//  - Abort=1 in any non-IDLE state: next cycle is IDLE, all outputs at reset values except
//    Exp_time (kept), and no Frame_done. Abort in IDLE has no effect. Abort has priority over
//    Continuous restart.
//  - Continuous is sampled in DONE only. Restart uses the Exp_time current at that edge.
// STRUCTURE
//  - Package pixel_ctrl_pkg holds the state enum (IDLE, ERASE, EXPOSE, SETUP, CONVERT, DONE)
//    and the shared phase-counter width function.
//  - One sub-module, exp_time_reg: saturating up/down register with the EXP_* parameters,
//    enable, and Exp_time output.
//  - The main FSM uses one shared phase counter, reloaded on every state entry.
// TESTING (defaults)
//  1. Reset, then Init pulse at cycle 0 -> Erase high cycles 1-2; Expose 3-6; NRE=2'b10 cycles
//     7-9 with ADC 8-9; NRE=2'b01 cycles 10-12 with ADC 11-12; Frame_done at 13; Busy low at 14.
//  2. Hold Exp_increase for 40 cycles in IDLE -> Exp_time saturates at 30. Hold Exp_decrease for
//     40 cycles -> Exp_time saturates at 2. Both high -> unchanged.
//  3. Exp_increase during EXPOSE -> Exp_time unchanged. Init together with Exp_increase in
//     IDLE -> frame uses 4, Exp_time stays 4.
//  4. Continuous=1 -> Erase reasserts the cycle after Frame_done, with no IDLE cycle. Drop
//    Continuous -> exactly one more frame, then IDLE.
//  5. Abort during CONVERT of row 0 -> next cycle NRE=2'b11, ADC=0, Busy=0, no Frame_done.
//     Reset mid-EXPOSE -> all reset values, Exp_time=4.
//  6. NUM_ROWS=5, EXP_DEFAULT=3 -> five sequential single-low NRE windows, rows 0 to 4;
//     frame length 2+3+15+1=21 cycles.

Source files
------------

// File: rtl/pixel_ctrl_pkg.sv
// Shared types for the pixel array readout controller.
// State encoding and phase-counter sizing helper.
package pixel_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ERASE,
    EXPOSE,
    SETUP,
    CONVERT,
    DONE
  } state_t;

  // Counter holds (length - 1), so $clog2 of the longest phase is enough.
  function automatic int phase_w(
    input int a,
    input int b,
    input int c,
    input int d
  );
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/pixel_array_readout_ctrl_exp_time_reg.sv
// Saturating up/down exposure-time register.
// One step per enabled cycle; both requests together hold the value.
module exp_time_reg
  import pixel_ctrl_pkg::*;
#(
  parameter int EXP_W       = 5,
  parameter int EXP_MIN     = 2,
  parameter int EXP_MAX     = 30,
  parameter int EXP_DEFAULT = 4,
  parameter int EXP_STEP    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             inc,
  input  logic             dec,
  output logic [EXP_W-1:0] exp_time
);

  localparam logic [EXP_W:0] STEP_W = (EXP_W+1)'(EXP_STEP);
  localparam logic [EXP_W:0] MAX_W  = (EXP_W+1)'(EXP_MAX);
  localparam logic [EXP_W:0] LOW_W  = (EXP_W+1)'(EXP_MIN + EXP_STEP);
  localparam logic [EXP_W-1:0] MAX_N = EXP_W'(EXP_MAX);
  localparam logic [EXP_W-1:0] MIN_N = EXP_W'(EXP_MIN);
  localparam logic [EXP_W-1:0] DEF_N = EXP_W'(EXP_DEFAULT);

  logic [EXP_W:0] wide;
  logic [EXP_W:0] up;
  logic [EXP_W:0] dn;

  assign wide = {1'b0, exp_time};
  assign up   = wide + STEP_W;
  assign dn   = wide - STEP_W;

  always_ff @(posedge clk) begin
    if (rst) begin
      exp_time <= DEF_N;
    end else if (en) begin
      unique case (1'b1)
        inc && !dec:
          exp_time <= (up > MAX_W) ? MAX_N : up[EXP_W-1:0];
        dec && !inc:
          exp_time <= (wide < LOW_W) ? MIN_N : dn[EXP_W-1:0];
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/pixel_array_readout_ctrl.sv
// Erase / expose / row-readout sequencer for a NUM_ROWS pixel array.
// Outputs are registered from the next-state decode.
module pixel_array_readout_ctrl
  import pixel_ctrl_pkg::*;
#(
  parameter int NUM_ROWS     = 2,
  parameter int EXP_W        = 5,
  parameter int EXP_MIN      = 2,
  parameter int EXP_MAX      = 30,
  parameter int EXP_DEFAULT  = 4,
  parameter int EXP_STEP     = 1,
  parameter int ERASE_CYCLES = 2,
  parameter int SETUP_CYCLES = 1,
  parameter int ADC_CYCLES   = 2,
  localparam int RW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                Exp_increase,
  input  logic                Exp_decrease,
  input  logic                Init,
  input  logic                Continuous,
  input  logic                Abort,
  output logic [NUM_ROWS-1:0] NRE,
  output logic                ADC,
  output logic                Expose,
  output logic                Erase,
  output logic                Busy,
  output logic [RW-1:0]       Row_idx,
  output logic [EXP_W-1:0]    Exp_time,
  output logic                Frame_done
);

  localparam int CW = phase_w(ERASE_CYCLES, EXP_MAX,
                              SETUP_CYCLES, ADC_CYCLES);
  localparam logic [CW-1:0] ERASE_LD = CW'(ERASE_CYCLES - 1);
  localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] ADC_LD   = CW'(ADC_CYCLES - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(NUM_ROWS - 1);

  state_t            state, nstate;
  logic [CW-1:0]     cnt, ncnt;
  logic [RW-1:0]     row, nrow;
  logic [EXP_W-1:0]  snap, nsnap;
  logic [NUM_ROWS-1:0] nre_n;
  logic              rd;
  logic              adj_en;

  assign adj_en  = (state == IDLE) && !Init;
  assign Row_idx = row;

  exp_time_reg #(
    .EXP_W      (EXP_W),
    .EXP_MIN    (EXP_MIN),
    .EXP_MAX    (EXP_MAX),
    .EXP_DEFAULT(EXP_DEFAULT),
    .EXP_STEP   (EXP_STEP)
  ) u_exp (
    .clk     (Clk),
    .rst     (Reset),
    .en      (adj_en),
    .inc     (Exp_increase),
    .dec     (Exp_decrease),
    .exp_time(Exp_time)
  );

  always_comb begin
    nstate = state;
    ncnt   = (cnt == '0) ? cnt : cnt - 1'b1;
    nrow   = row;
    nsnap  = snap;
    unique case (state)
      IDLE: if (Init) begin
        nstate = ERASE;
        ncnt   = ERASE_LD;
        nsnap  = Exp_time;
      end
      ERASE: if (cnt == '0) begin
        nstate = EXPOSE;
        ncnt   = CW'(snap - 1'b1);
      end
      EXPOSE: if (cnt == '0) begin
        nstate = SETUP;
        ncnt   = SETUP_LD;
      end
      SETUP: if (cnt == '0) begin
        nstate = CONVERT;
        ncnt   = ADC_LD;
      end
      CONVERT: if (cnt == '0) begin
        if (row == LAST_ROW) begin
          nstate = DONE;
          ncnt   = '0;
        end else begin
          nstate = SETUP;
          ncnt   = SETUP_LD;
          nrow   = row + 1'b1;
        end
      end
      DONE: begin
        nrow = '0;
        if (Continuous) begin
          nstate = ERASE;
          ncnt   = ERASE_LD;
          nsnap  = Exp_time;
        end else begin
          nstate = IDLE;
        end
      end
      default: nstate = IDLE;
    endcase
    // Abort beats every transition, including a continuous restart.
    if (Abort && state != IDLE) begin
      nstate = IDLE;
      ncnt   = '0;
      nrow   = '0;
    end
  end

  always_comb begin
    rd = (nstate == SETUP) || (nstate == CONVERT);
    for (int i = 0; i < NUM_ROWS; i++)
      nre_n[i] = !(rd && nrow == RW'(i));
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= IDLE;
      cnt        <= '0;
      row        <= '0;
      snap       <= EXP_W'(EXP_DEFAULT);
      NRE        <= '1;
      ADC        <= 1'b0;
      Expose     <= 1'b0;
      Erase      <= 1'b0;
      Busy       <= 1'b0;
      Frame_done <= 1'b0;
    end else begin
      state      <= nstate;
      cnt        <= ncnt;
      row        <= nrow;
      snap       <= nsnap;
      NRE        <= nre_n;
      ADC        <= (nstate == CONVERT);
      Expose     <= (nstate == EXPOSE);
      Erase      <= (nstate == ERASE);
      Busy       <= (nstate != IDLE);
      Frame_done <= (nstate == DONE);
    end
  end

endmodule

// File: tb/tb_pixel_array_readout_ctrl.sv
// Randomized bench for pixel_array_readout_ctrl against a frame-position model.
// Runs a 2-row default instance and a 5-row instance on the same inputs.
module tb_pixel_array_readout_ctrl;

  localparam int E = 2;
  localparam int S = 1;
  localparam int A = 2;
  localparam int XMIN = 2;
  localparam int XMAX = 30;

  typedef struct {
    bit act;
    int pos;
    int snap;
    int exp;
  } mst_t;

  typedef struct {
    int nre;
    int adc;
    int expo;
    int era;
    int busy;
    int row;
    int fd;
    int exp;
  } out_t;

  logic Clk = 0;
  logic Reset = 1;
  logic Exp_increase = 0;
  logic Exp_decrease = 0;
  logic Init = 0;
  logic Continuous = 0;
  logic Abort = 0;

  logic [1:0] NRE;
  logic ADC, Expose, Erase, Busy, Frame_done;
  logic [0:0] Row_idx;
  logic [4:0] Exp_time;

  logic [4:0] NRE5;
  logic ADC5, Expose5, Erase5, Busy5, Frame_done5;
  logic [2:0] Row_idx5;
  logic [4:0] Exp_time5;

  int n_chk = 0;
  int n_err = 0;
  int bcnt = 0;
  int bcnt5 = 0;
  mst_t m2, m5;

  always #5 Clk = ~Clk;

  pixel_array_readout_ctrl dut (
    .Clk(Clk), .Reset(Reset),
    .Exp_increase(Exp_increase), .Exp_decrease(Exp_decrease),
    .Init(Init), .Continuous(Continuous), .Abort(Abort),
    .NRE(NRE), .ADC(ADC), .Expose(Expose), .Erase(Erase),
    .Busy(Busy), .Row_idx(Row_idx), .Exp_time(Exp_time),
    .Frame_done(Frame_done)
  );

  pixel_array_readout_ctrl #(.NUM_ROWS(5), .EXP_DEFAULT(3)) dut5 (
    .Clk(Clk), .Reset(Reset),
    .Exp_increase(Exp_increase), .Exp_decrease(Exp_decrease),
    .Init(Init), .Continuous(Continuous), .Abort(Abort),
    .NRE(NRE5), .ADC(ADC5), .Expose(Expose5), .Erase(Erase5),
    .Busy(Busy5), .Row_idx(Row_idx5), .Exp_time(Exp_time5),
    .Frame_done(Frame_done5)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int flen(input int snap, input int nr);
    return E + snap + nr * (S + A) + 1;
  endfunction

  function automatic mst_t mstep(input mst_t s, input int nr, input int def,
                                 input bit rst, input bit ini, input bit con,
                                 input bit abt, input bit inc, input bit dec);
    mst_t n = s;
    if (rst) begin
      n.act = 0; n.pos = 0; n.snap = def; n.exp = def;
    end else if (s.act) begin
      if (abt) n.act = 0;
      else if (s.pos == flen(s.snap, nr)) begin
        if (con) begin n.pos = 1; n.snap = s.exp; end
        else n.act = 0;
      end else n.pos = s.pos + 1;
    end else if (ini) begin
      n.act = 1; n.pos = 1; n.snap = s.exp;
    end else if (inc && !dec) begin
      n.exp = (s.exp + 1 > XMAX) ? XMAX : s.exp + 1;
    end else if (dec && !inc) begin
      n.exp = (s.exp - 1 < XMIN) ? XMIN : s.exp - 1;
    end
    return n;
  endfunction

  function automatic out_t mout(input mst_t s, input int nr);
    out_t o;
    int k;
    o = '{nre: (1 << nr) - 1, adc: 0, expo: 0, era: 0,
          busy: 0, row: 0, fd: 0, exp: s.exp};
    if (s.act) begin
      o.busy = 1;
      if (s.pos <= E) o.era = 1;
      else if (s.pos <= E + s.snap) o.expo = 1;
      else if (s.pos < flen(s.snap, nr)) begin
        k = s.pos - E - s.snap - 1;
        o.row = k / (S + A);
        o.nre = o.nre & ~(1 << o.row);
        o.adc = ((k % (S + A)) >= S) ? 1 : 0;
      end else begin
        o.fd = 1;
        o.row = nr - 1;
      end
    end
    return o;
  endfunction

  task automatic compare();
    out_t o;
    o = mout(m2, 2);
    check("nre", int'(NRE), o.nre);
    check("adc", int'(ADC), o.adc);
    check("expose", int'(Expose), o.expo);
    check("erase", int'(Erase), o.era);
    check("busy", int'(Busy), o.busy);
    check("row", int'(Row_idx), o.row);
    check("frame_done", int'(Frame_done), o.fd);
    check("exp_time", int'(Exp_time), o.exp);
    o = mout(m5, 5);
    check("nre5", int'(NRE5), o.nre);
    check("adc5", int'(ADC5), o.adc);
    check("expose5", int'(Expose5), o.expo);
    check("erase5", int'(Erase5), o.era);
    check("busy5", int'(Busy5), o.busy);
    check("row5", int'(Row_idx5), o.row);
    check("frame_done5", int'(Frame_done5), o.fd);
    check("exp_time5", int'(Exp_time5), o.exp);
  endtask

  task automatic tick();
    @(posedge Clk);
    m2 = mstep(m2, 2, 4, Reset, Init, Continuous, Abort,
               Exp_increase, Exp_decrease);
    m5 = mstep(m5, 5, 3, Reset, Init, Continuous, Abort,
               Exp_increase, Exp_decrease);
    @(negedge Clk);
    compare();
    if (Busy) bcnt++;
    if (Busy5) bcnt5++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    m2 = '{act: 0, pos: 0, snap: 4, exp: 4};
    m5 = '{act: 0, pos: 0, snap: 3, exp: 3};
    ticks(2);
    Reset = 0;
    ticks(1);

    // Single-shot frame length for both row counts.
    bcnt = 0; bcnt5 = 0;
    Init = 1; tick(); Init = 0;
    ticks(24);
    check("frame_len2", bcnt, 13);
    check("frame_len5", bcnt5, 21);

    // Saturation both ways, then both requests together.
    Exp_increase = 1; ticks(40); Exp_increase = 0; tick();
    check("sat_hi", int'(Exp_time), 30);
    Exp_decrease = 1; ticks(40); Exp_decrease = 0; tick();
    check("sat_lo", int'(Exp_time), 2);
    Exp_increase = 1; Exp_decrease = 1; ticks(5);
    Exp_increase = 0; Exp_decrease = 0; tick();
    check("both_hold", int'(Exp_time), 2);

    // Adjust ignored while exposing.
    Init = 1; tick(); Init = 0;
    ticks(3);
    Exp_increase = 1; tick(); Exp_increase = 0;
    check("adj_busy", int'(Exp_time), 2);
    ticks(20);

    // Init beats a simultaneous increase.
    Exp_increase = 1; ticks(2); Exp_increase = 0;
    Init = 1; Exp_increase = 1; tick();
    Init = 0; Exp_increase = 0;
    check("init_wins", int'(Exp_time), 4);
    ticks(25);

    // Continuous run, then drop it.
    Continuous = 1; Init = 1; tick(); Init = 0;
    ticks(30);
    Continuous = 0;
    ticks(40);

    // Abort during CONVERT of row 0.
    Init = 1; tick(); Init = 0;
    ticks(7);
    Abort = 1; tick(); Abort = 0;
    check("abort_busy", int'(Busy), 0);
    check("abort_nre", int'(NRE), 3);
    ticks(3);

    // Reset mid-exposure.
    Exp_increase = 1; ticks(3); Exp_increase = 0;
    Init = 1; tick(); Init = 0;
    ticks(4);
    Reset = 1; tick(); Reset = 0;
    check("reset_exp", int'(Exp_time), 4);
    ticks(2);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      Init = ($urandom_range(7) == 0);
      Exp_increase = ($urandom_range(3) == 0);
      Exp_decrease = ($urandom_range(3) == 0);
      Abort = ($urandom_range(63) == 0);
      Reset = ($urandom_range(255) == 0);
      if ($urandom_range(31) == 0) Continuous = ~Continuous;
      tick();
    end
    Init = 0; Abort = 0; Reset = 0; Continuous = 0;
    Exp_increase = 0; Exp_decrease = 0;
    ticks(60);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
